// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: beat layout, video packet type and write-FSM states shared by the packetizer.
package pixel_stream_pkg;
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [11:0] data;
    } beat_t;
    localparam logic [3:0] VIDEO_PKT_TYPE = 4'h0;
    typedef enum logic [1:0] {IDLE, HEADER, ACTIVE} wr_state_t;
endpackage

// File: rtl/pixel_packetizer_if.sv
// pixel_packetizer_if: pixel input, Avalon-ST output and status flags of the packetizer.
interface pixel_packetizer_if;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic        frame_start;
    logic [11:0] data_out;
    logic        sop_out;
    logic        eop_out;
    logic        valid_out;
    logic        ready_in;
    logic        overflow;
    logic        frame_err;
    modport master (
        output pix_data, pix_valid, frame_start, ready_in,
        input  data_out, sop_out, eop_out, valid_out, overflow, frame_err
    );
    modport slave (
        input  pix_data, pix_valid, frame_start, ready_in,
        output data_out, sop_out, eop_out, valid_out, overflow, frame_err
    );
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO; head reads as zero while empty.
module stream_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en, rd_en;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/pixel_packetizer.sv
// pixel_packetizer: frames an unstallable pixel stream into Avalon-ST packets; PIXEL_PACKETIZER_HEADER_EN adds a header beat.
module pixel_packetizer
    import pixel_stream_pkg::*;
#(
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480,
    parameter int FIFO_DEPTH = 16
) (
    input logic               clock_clk,
    input logic               reset_n,
    pixel_packetizer_if.slave bus
);
`ifdef PIXEL_PACKETIZER_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif
    localparam int XW = FRAME_W > 1 ? $clog2(FRAME_W) : 1;
    localparam int YW = FRAME_H > 1 ? $clog2(FRAME_H) : 1;
    localparam logic [XW-1:0] XMAX = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(FRAME_H - 1);
    wr_state_t       state, next_state, start_state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            full, empty, push, pop, clr, adv, set_ovf, set_err, last;
    logic            ovf_q, err_q;
    beat_t           wr_beat, head;
    assign start_state = HDR_EN ? HEADER : ACTIVE;
    assign last        = (x == XMAX) && (y == YMAX);
    always_ff @(posedge clock_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = bus.frame_start ? start_state : IDLE;
            HEADER:  next_state = bus.frame_start ? HEADER : (full ? HEADER : ACTIVE);
            ACTIVE:  next_state = bus.frame_start ? start_state : ((bus.pix_valid && last) ? IDLE : ACTIVE);
            default: next_state = IDLE;
        endcase
    end
    // frame_start always wins: any pixel coincident with it belongs to the abandoned frame
    always_comb begin
        clr     = bus.frame_start;
        set_err = bus.frame_start && state != IDLE;
        push    = !bus.frame_start && !full && (state == HEADER || (state == ACTIVE && bus.pix_valid));
        adv     = !bus.frame_start && state == ACTIVE && bus.pix_valid;
        set_ovf = !bus.frame_start && bus.pix_valid && (state == HEADER || (state == ACTIVE && full));
        wr_beat = state == HEADER ? {1'b1, 1'b0, 8'h00, VIDEO_PKT_TYPE}
                                  : {!HDR_EN && x == '0 && y == '0, last, bus.pix_data};
    end
    always_ff @(posedge clock_clk or negedge reset_n) begin
        if (!reset_n) begin
            x     <= '0;
            y     <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (clr) begin
                x <= '0;
                y <= '0;
            end else if (adv) begin
                x <= x == XMAX ? '0 : x + XW'(1);
                if (x == XMAX) y <= y == YMAX ? '0 : y + YW'(1);
            end
            ovf_q <= ovf_q | set_ovf;
            err_q <= err_q | set_err;
        end
    end
    assign pop = !empty && bus.ready_in;
    stream_fifo #(.WIDTH($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clock_clk),
        .rst_n (reset_n),
        .push  (push),
        .pop   (pop),
        .din   (wr_beat),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    assign bus.valid_out = !empty;
    assign bus.data_out  = head.data;
    assign bus.sop_out   = head.sop;
    assign bus.eop_out   = head.eop;
    assign bus.overflow  = ovf_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_pixel_packetizer.sv
// tb_pixel_packetizer: randomized bench against a frame-level reference model of the packetizer.
module tb_pixel_packetizer;
    import pixel_stream_pkg::*;
    localparam int W = 4, H = 2, D = 4, N = W * H;
`ifdef PIXEL_PACKETIZER_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    logic clock_clk = 1'b0;
    logic reset_n   = 1'b0;
    pixel_packetizer_if bus ();
    pixel_packetizer #(.FRAME_W(W), .FRAME_H(H), .FIFO_DEPTH(D)) dut (
        .clock_clk (clock_clk),
        .reset_n   (reset_n),
        .bus       (bus.slave)
    );
    always #5 clock_clk = ~clock_clk;
    int    n_tests = 0, n_fail = 0, rmode = 0, beats = 0, eops = 0;
    beat_t q[$];
    bit    m_ovf, m_err, in_frame, hdr_pend;
    int    idx;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_clear();
        q.delete();
        m_ovf = 0; m_err = 0; in_frame = 0; hdr_pend = 0; idx = 0;
    endtask
    // one clock edge of the packet rules: frame tracking, drop-when-full, FWFT queue
    task automatic model_step();
        bit    full = q.size() == D;
        bit    pop  = q.size() > 0 && bus.ready_in;
        bit    push = 0;
        beat_t b    = '0;
        if (bus.frame_start) begin
            if (in_frame) m_err = 1;
            in_frame = 1; hdr_pend = HDR; idx = 0;
        end else if (in_frame && hdr_pend) begin
            if (bus.pix_valid) m_ovf = 1;
            if (!full) begin
                push = 1; b = '{1'b1, 1'b0, 12'h000}; hdr_pend = 0;
            end
        end else if (in_frame && bus.pix_valid) begin
            b.sop  = !HDR && idx == 0;
            b.eop  = idx == N - 1;
            b.data = bus.pix_data;
            if (full) m_ovf = 1;
            else push = 1;
            idx++;
            if (idx == N) in_frame = 0;
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(b);
    endtask
    task automatic compare();
        check("valid", bus.valid_out, q.size() > 0);
        if (q.size() > 0) begin
            check("data", bus.data_out, q[0].data);
            check("sop", bus.sop_out, q[0].sop);
            check("eop", bus.eop_out, q[0].eop);
        end
        check("ovf", bus.overflow, m_ovf);
        check("err", bus.frame_err, m_err);
    endtask
    task automatic drive(input bit fs, input bit pv, input logic [11:0] pd);
        bus.frame_start = fs;
        bus.pix_valid   = pv;
        bus.pix_data    = pd;
        bus.ready_in    = rmode == 0 ? 1'b1 : rmode == 1 ? 1'b0 : rmode == 2 ? ~bus.ready_in : 1'($urandom_range(0, 1));
        if (bus.valid_out && bus.ready_in) begin
            beats++;
            if (bus.eop_out) eops++;
        end
        @(posedge clock_clk);
        if (reset_n) model_step();
        #1 compare();
    endtask
    task automatic idle(input int n);
        repeat (n) drive(0, 0, 12'h000);
    endtask
    task automatic send_frame(input int npix, input bit seq, input int min_gap, input int max_gap);
        drive(1, 0, 12'h000);
        drive(0, 0, 12'h000);
        for (int k = 0; k < npix; k++) begin
            repeat ($urandom_range(min_gap, max_gap)) drive(0, 0, 12'h000);
            drive(0, 1, seq ? 12'(k + 1) : 12'($urandom));
        end
    endtask
    initial begin
        bus.frame_start = 0; bus.pix_valid = 0; bus.pix_data = '0; bus.ready_in = 1;
        model_clear();
        repeat (2) @(posedge clock_clk);
        #1 compare();
        reset_n = 1;
        rmode = 0; beats = 0; eops = 0;
        send_frame(N, 1, 0, 0);
        idle(4);
        check("t1_beats", beats, N + HDR);
        check("t1_eops", eops, 1);
        rmode = 1; beats = 0;
        send_frame(N, 1, 0, 0);
        idle(2);
        check("t3_ovf", bus.overflow, 1);
        rmode = 0;
        idle(8);
        check("t3_beats", beats, D);
        send_frame(3, 1, 0, 0);
        beats = 0; eops = 0;
        send_frame(N, 1, 0, 0);
        idle(4);
        check("t4_err", bus.frame_err, 1);
        check("t4_eops", eops, 1);
        rmode = 1;
        send_frame(3 - HDR, 1, 0, 0);
        #2 reset_n = 0;
        #1;
        check("rst_valid", bus.valid_out, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_err", bus.frame_err, 0);
        check("rst_sop", bus.sop_out, 0);
        check("rst_data", bus.data_out, 0);
        model_clear();
        drive(0, 0, 12'h000);
        reset_n = 1;
        rmode = 0; beats = 0; eops = 0;
        send_frame(N, 1, 0, 0);
        idle(4);
        check("t5_beats", beats, N + HDR);
        rmode = 2; beats = 0; eops = 0;
        send_frame(N, 1, 1, 1);
        rmode = 0;
        idle(8);
        check("t6_beats", beats, N + HDR);
        check("t6_ovf", bus.overflow, 0);
        repeat (25) begin
            rmode = 3;
            send_frame($urandom_range(0, 3) == 0 ? $urandom_range(1, N - 1) : N, 0, 0, 2);
            idle($urandom_range(0, 3));
        end
        rmode = 0;
        idle(12);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_packetizer.md
PIXEL_PACKETIZER -- requirements
Module: pixel_packetizer

Interface
REQ-001 SHALL have parameter FRAME_W, 640, active pixels per line.
REQ-002 SHALL have parameter FRAME_H, 480, active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, 16, output buffer entries (power of 2, >=4).
REQ-004 SHALL have port clock_clk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port pix_data  in  12  RGB 4:4:4 pixel, {R[11:8],G[7:4],B[3:0]}.
REQ-007 SHALL have port pix_valid  in  1  pix_data valid this cycle; source cannot be stalled.
REQ-008 SHALL have port frame_start  in  1  one-cycle pulse, >=2 cycles before a frame's first pix_valid.
REQ-009 SHALL have port data_out  out  12  Avalon-ST beat data.
REQ-010 SHALL have port sop_out  out  1  start of packet.
REQ-011 SHALL have port eop_out  out  1  end of packet.
REQ-012 SHALL have port valid_out  out  1  beat valid.
REQ-013 SHALL have port ready_in  in  1  downstream ready.
REQ-014 SHALL have port overflow  out  1  sticky: a beat was dropped.
REQ-015 SHALL have port frame_err  out  1  sticky: frame_start arrived mid-frame.

Function
REQ-016 SHALL use write FSM states IDLE, HEADER, ACTIVE; encoding free.
REQ-017 IDLE: pix_valid ignored; frame_start -> HEADER (macro on) or ACTIVE (macro off); x,y counters cleared.
REQ-018 HEADER: push beat {sop=1,eop=0,data=12'h000} when FIFO not full, then -> ACTIVE; if full, hold HEADER; pix_valid in HEADER drops pixel, sets overflow.
REQ-019 ACTIVE: each pix_valid pushes {sop,eop,pix_data}; x increments, wraps at FRAME_W-1 with y increment.
REQ-020 sop=1 on pixel (0,0) only when macro off; eop=1 on pixel (FRAME_W-1,FRAME_H-1); after that push -> IDLE.
REQ-021 pix_valid with FIFO full in ACTIVE: pixel dropped, overflow set, counters still advance (geometry preserved, eop may be lost).
REQ-022 frame_start in HEADER or ACTIVE: frame_err set, counters cleared, restart at HEADER/ACTIVE; unfinished packet left without eop.
REQ-023 FIFO full blocks push even if a pop occurs same cycle; push and pop otherwise simultaneous.
REQ-024 valid_out = FIFO not empty; data/sop/eop show head entry (first-word-fall-through); pop when valid_out && ready_in.
REQ-025 Latency: beat pushed at edge N visible on outputs after edge N (one cycle), no combinational input-to-output path.
REQ-026 Outputs SHALL hold stable while valid_out && !ready_in.
REQ-027 overflow and frame_err clear only on reset.

Reset
REQ-028 reset_n low SHALL asynchronously force: FSM IDLE, counters 0, FIFO empty, valid_out/sop_out/eop_out 0, data_out 0, overflow 0, frame_err 0.
REQ-029 Reset mid-frame SHALL discard all buffered beats; no partial packet emitted after release.

Configuration
REQ-030 Macro PIXEL_PACKETIZER_HEADER_EN defined: HEADER state present, each packet = one header beat (sop, type 0) + FRAME_W*FRAME_H pixels.
REQ-031 Macro undefined: HEADER state absent, sop on first pixel, packet = FRAME_W*FRAME_H pixels.

Structure
REQ-032 Package pixel_stream_pkg SHALL hold typedef beat_t {sop,eop,data[11:0]}, constant VIDEO_PKT_TYPE=4'h0, and FSM state enum.
REQ-033 FIFO SHALL be sub-module stream_fifo (parameterised width/depth, FWFT, full/empty).

Verification (FRAME_W=4, FRAME_H=2, FIFO_DEPTH=4)
REQ-034 Macro off, ready_in=1, frame_start then 8 pixels 0x001..0x008 -> 8 beats, sop on 0x001, eop on 0x008, each 1 cycle after input.
REQ-035 Macro on, same stimulus -> 9 beats: 0x000 with sop, then 0x001..0x008, eop on 0x008.
REQ-036 ready_in=0 throughout 8 pixels -> first 4 buffered, remaining 4 dropped, overflow=1; ready_in=1 then yields 4 beats unchanged.
REQ-037 frame_start after 3 pixels -> frame_err=1, next 8 pixels form full packet with sop/eop correct.
REQ-038 reset_n low for 1 cycle with 3 beats buffered -> valid_out=0 immediately, flags 0, next frame correct.
REQ-039 ready_in toggled every cycle -> no beat lost/duplicated, outputs stable while stalled.
